// File: rtl/nibble_alu_accum.sv
// nibble_alu_accum: registered arithmetic unit for two WIDTH-bit operands.
// Supports add, subtract, accumulate and sequential multiply, with a
// persistent accumulator and valid/ready handshakes on input and output.
// Results sit in an output register until the consumer takes them.
// Optional feature: define NIBBLE_ALU_SAT_EN to make the accumulate mode
// saturate at the accumulator maximum instead of wrapping around.

// Protocol checker, instantiated by the top level; ignored by synthesis flows.
module nibble_alu_accum_checker #(
    parameter int ACC_W = 8
) (
    input logic             clk,
    input logic             reset,
    input logic             busy,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [ACC_W-1:0] result,
    input logic             flag
);

    // A stalled result must stay put until the consumer takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(flag)));

    // No new operation is accepted while a multiply is in flight.
    a_busy_not_ready: assert property (@(posedge clk) disable iff (reset)
        busy |-> !in_ready);

endmodule

module nibble_alu_accum #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             flag
);

    // The multiply result and the accumulator both live in ACC_W bits.
    generate
        if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
            $error("nibble_alu_accum: ACC_W must be at least 2*WIDTH");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("nibble_alu_accum: WIDTH must be at least 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_MUL = 2'b11
    } mode_e;

    state_e             state_r;
    state_e             state_next_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               mul_start_s;
    logic               mul_done_s;

    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_next_s;
    logic               acc_load_s;
    logic               sat_set_s;

    logic [ACC_W-1:0]   result_r;
    logic               flag_r;
    logic               out_valid_r;

    logic [ACC_W-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [ACC_W-1:0]   prod_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   prod_step_s;

    logic [ACC_W-1:0]   a_ext_s;
    logic [ACC_W-1:0]   b_ext_s;
    logic [WIDTH:0]     add_sum_s;
    logic [ACC_W-1:0]   acc_base_s;
    logic [ACC_W:0]     acc_sum_s;
    logic [ACC_W-1:0]   op_result_s;
    logic               op_flag_s;

`ifdef NIBBLE_ALU_SAT_EN
    logic               sat_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flag      = flag_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state, handshake and multiply sequencing controls.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        mul_start_s  = 1'b0;
        mul_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!reset && (!out_valid_r || out_ready)) begin
                    in_ready_s = 1'b1;
                end else begin
                    in_ready_s = 1'b0;
                end
                accept_s = in_valid && in_ready_s;
                if (accept_s && (mode == MODE_MUL)) begin
                    mul_start_s  = 1'b1;
                    state_next_s = ST_MUL_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    mul_done_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_MUL_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Single-cycle datapath for add, subtract and accumulate.
    always_comb begin
        a_ext_s     = {{(ACC_W - WIDTH){1'b0}}, a};
        b_ext_s     = {{(ACC_W - WIDTH){1'b0}}, b};
        add_sum_s   = {1'b0, a} + {1'b0, b};
        // A coincident clear zeroes the accumulator before this op adds in.
        acc_base_s  = clear ? {ACC_W{1'b0}} : acc_r;
        acc_sum_s   = {1'b0, acc_base_s} + {1'b0, a_ext_s} + {1'b0, b_ext_s};
        op_result_s = {ACC_W{1'b0}};
        op_flag_s   = 1'b0;
        acc_next_s  = acc_r;
        acc_load_s  = 1'b0;
        sat_set_s   = 1'b0;
        case (mode)
            MODE_ADD: begin
                op_result_s = {{(ACC_W - WIDTH - 1){1'b0}}, add_sum_s};
                op_flag_s   = add_sum_s[WIDTH];
            end
            MODE_SUB: begin
                op_result_s = a_ext_s - b_ext_s;
                op_flag_s   = (a < b);
            end
            MODE_ACC: begin
`ifdef NIBBLE_ALU_SAT_EN
                // Once saturated, stay pinned at max until a clear.
                if (acc_sum_s[ACC_W] || (sat_r && !clear)) begin
                    op_result_s = {ACC_W{1'b1}};
                    op_flag_s   = 1'b1;
                    sat_set_s   = 1'b1;
                end else begin
                    op_result_s = acc_sum_s[ACC_W-1:0];
                    op_flag_s   = 1'b0;
                    sat_set_s   = 1'b0;
                end
`else
                op_result_s = acc_sum_s[ACC_W-1:0];
                op_flag_s   = acc_sum_s[ACC_W];
                sat_set_s   = 1'b0;
`endif
                acc_next_s  = op_result_s;
                acc_load_s  = accept_s;
            end
            MODE_MUL: begin
                op_result_s = {ACC_W{1'b0}};
                op_flag_s   = 1'b0;
            end
            default: begin
                op_result_s = {ACC_W{1'b0}};
                op_flag_s   = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit (LSB first) is set.
    always_comb begin
        if (mplier_r[0]) begin
            prod_step_s = prod_r + mcand_r;
        end else begin
            prod_step_s = prod_r;
        end
    end

    // Accumulator: loaded by accepted ACC ops, zeroed by a lone clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (acc_load_s) begin
            acc_r <= acc_next_s;
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_r;
        end
    end

`ifdef NIBBLE_ALU_SAT_EN
    // Sticky saturation marker, released only by clear or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_r <= 1'b0;
        end else if (acc_load_s) begin
            sat_r <= sat_set_s;
        end else if (clear) begin
            sat_r <= 1'b0;
        end else begin
            sat_r <= sat_r;
        end
    end
`endif

    // Multiply operand, partial product and bit counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {ACC_W{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {ACC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (mul_start_s) begin
            mcand_r  <= a_ext_s;
            mplier_r <= b;
            prod_r   <= {ACC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_MUL_BUSY) begin
            mcand_r  <= {mcand_r[ACC_W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            prod_r   <= prod_step_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            prod_r   <= prod_r;
            cnt_r    <= cnt_r;
        end
    end

    // Output register: load on completion, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= {ACC_W{1'b0}};
            flag_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s && (mode != MODE_MUL)) begin
            result_r    <= op_result_s;
            flag_r      <= op_flag_s;
            out_valid_r <= 1'b1;
        end else if (mul_done_s) begin
            result_r    <= prod_step_s;
            flag_r      <= 1'b0;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            result_r    <= result_r;
            flag_r      <= flag_r;
            out_valid_r <= 1'b0;
        end else begin
            result_r    <= result_r;
            flag_r      <= flag_r;
            out_valid_r <= out_valid_r;
        end
    end

    nibble_alu_accum_checker #(
        .ACC_W (ACC_W)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .busy      (state_r == ST_MUL_BUSY),
        .in_ready  (in_ready_s),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .result    (result_r),
        .flag      (flag_r)
    );

endmodule

// File: tb/tb_nibble_alu_accum.sv
// Directed testbench for nibble_alu_accum (WIDTH=4, ACC_W=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Accumulate expectations follow NIBBLE_ALU_SAT_EN when it is defined.
module tb_nibble_alu_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] mode;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nibble_alu_accum #(.WIDTH(4), .ACC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd8; mode = 2'b00;
        clear = 1'b0; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (result !== 8'h00) begin miscompares++; $display("FAIL reset_result: got %h want 00", result); end
        vectors++;
        if (flag !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b want 0", flag); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        in_valid = 1'b1; mode = 2'b00; a = 4'd9; b = 4'd8; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b want 1", out_valid); end
        vectors++;
        if (result !== 8'h11) begin miscompares++; $display("FAIL add_result: got %h want 11", result); end
        vectors++;
        if (flag !== 1'b1) begin miscompares++; $display("FAIL add_flag: got %b want 1", flag); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_consumed: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; mode = 2'b01; a = 4'd3; b = 4'd5; out_ready = 1'b1;
        tick();
        a = 4'd5; b = 4'd3;
        vectors++;
        if (result !== 8'hFE) begin miscompares++; $display("FAIL sub_neg_result: got %h want fe", result); end
        vectors++;
        if (flag !== 1'b1) begin miscompares++; $display("FAIL sub_neg_flag: got %b want 1", flag); end
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sub_pos_valid: got %b want 1", out_valid); end
        vectors++;
        if (result !== 8'h02) begin miscompares++; $display("FAIL sub_pos_result: got %h want 02", result); end
        vectors++;
        if (flag !== 1'b0) begin miscompares++; $display("FAIL sub_pos_flag: got %b want 0", flag); end
        tick();
    endtask

    task automatic test_mul();
        in_valid = 1'b1; mode = 2'b11; a = 4'd15; b = 4'd13; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mul_busy_ready[%0d]: got %b want 0", k, in_ready); end
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mul_early_valid[%0d]: got %b want 0", k, out_valid); end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mul_valid: got %b want 1", out_valid); end
        vectors++;
        if (result !== 8'hC3) begin miscompares++; $display("FAIL mul_result: got %h want c3", result); end
        vectors++;
        if (flag !== 1'b0) begin miscompares++; $display("FAIL mul_flag: got %b want 0", flag); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mul_done_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_mul_reset();
        in_valid = 1'b1; mode = 2'b11; a = 4'd7; b = 4'd7; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mulrst_idle: got %b want 1", in_ready); end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mulrst_valid[%0d]: got %b want 0", k, out_valid); end
            tick();
        end
    endtask

    task automatic test_acc_wrap();
        int acc_m;
        int sum_m;
        int sat_m;
        logic [7:0] exp_r;
        logic       exp_f;
        acc_m = 0; sat_m = 0;
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1; mode = 2'b10; a = 4'd15; b = 4'd15;
        for (int k = 1; k <= 18; k++) begin
            sum_m = acc_m + 30;
`ifdef NIBBLE_ALU_SAT_EN
            if (sum_m >= 256 || sat_m != 0) begin
                acc_m = 255; exp_f = 1'b1; sat_m = 1;
            end else begin
                acc_m = sum_m; exp_f = 1'b0;
            end
`else
            exp_f = (sum_m >= 256);
            acc_m = sum_m % 256;
`endif
            exp_r = acc_m[7:0];
            tick();
            vectors++;
            if (result !== exp_r) begin miscompares++; $display("FAIL acc_result[%0d]: got %h want %h", k, result, exp_r); end
            vectors++;
            if (flag !== exp_f) begin miscompares++; $display("FAIL acc_flag[%0d]: got %b want %b", k, flag, exp_f); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_clear_acc();
        in_valid = 1'b1; mode = 2'b10; a = 4'd1; b = 4'd2; clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; a = 4'd1; b = 4'd0;
        vectors++;
        if (result !== 8'h03) begin miscompares++; $display("FAIL clracc_result: got %h want 03", result); end
        vectors++;
        if (flag !== 1'b0) begin miscompares++; $display("FAIL clracc_flag: got %b want 0", flag); end
        tick();
        vectors++;
        if (result !== 8'h04) begin miscompares++; $display("FAIL acc_after_clear: got %h want 04", result); end
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL clear_keeps_valid: got %b want 1", out_valid); end
        vectors++;
        if (result !== 8'h04) begin miscompares++; $display("FAIL clear_keeps_result: got %h want 04", result); end
        out_ready = 1'b1; in_valid = 1'b1; a = 4'd0; b = 4'd5;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (result !== 8'h05) begin miscompares++; $display("FAIL acc_from_zero: got %h want 05", result); end
        tick();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; mode = 2'b00; a = 4'd1; b = 4'd1; out_ready = 1'b0;
        tick();
        a = 4'd2; b = 4'd2;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (result !== 8'h02) begin miscompares++; $display("FAIL bp_result[%0d]: got %h want 02", k, result); end
            vectors++;
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
        vectors++;
        if (result !== 8'h04) begin miscompares++; $display("FAIL bp_next_result: got %h want 04", result); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_mul_reset();
        test_acc_wrap();
        test_clear_acc();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_alu_accum.md
# nibble_alu_accum

Parametrised successor to the single-cycle nibble adder: a registered arithmetic unit on two WIDTH-bit operands with four modes (add, subtract, accumulate, sequential multiply), a persistent accumulator and valid/ready handshakes on both sides. It sits between the dedicated-input pin decode and the output pin register in the top-level Tiny Tapeout wrapper; the wrapper drives operands from `ui_in` nibbles and maps `result` to `uo_out`.

## Interface
- `WIDTH`, 4: operand width in bits; ≥2.
- `ACC_W`, 8: accumulator/result width; must be ≥ 2*WIDTH (elaboration error otherwise).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand/mode presented.
- `in_ready`  out  1  block can accept this cycle.
- `a`, `b`  in  WIDTH each  unsigned operands.
- `mode`  in  2  00 ADD, 01 SUB, 10 ACC, 11 MUL.
- `clear`  in  1  zero the accumulator (independent of handshake).
- `out_valid`  out  1  `result`/`flag` hold a completed operation.
- `out_ready`  in  1  consumer takes result.
- `result`  out  ACC_W  operation result.
- `flag`  out  1  mode-specific status (carry/borrow/overflow).

## Operation
- FSM states: IDLE, MUL_BUSY. Reset → IDLE.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). Accept = `in_valid && in_ready`.
- ADD: `result` = zero-extend(a+b), WIDTH+1 bits; `flag` = bit WIDTH of sum (carry).
- SUB: `result` = (a−b) mod 2^ACC_W (two's complement, sign-extended); `flag` = 1 iff a<b.
- ACC: acc_next = acc + a + b computed in ACC_W+1 bits; `result` = acc_next[ACC_W−1:0]; `flag` = carry out of ACC_W; accumulator updated.
- MUL: shift-add, one multiplier bit (LSB first) per cycle; `result` = zero-extend(a*b) (2*WIDTH bits); `flag` = 0. Accumulator untouched.
- Output register: on completion loads `result`/`flag`, sets `out_valid`. Held stable while `out_valid && !out_ready`. Cleared when consumed with no new completion same cycle.
- `clear`: acc ← 0 on the edge. If coincident with an ACC accept, clear applies first: acc ← a+b, `flag`=0. `clear` does not touch `result`/`out_valid`; allowed in MUL_BUSY.
- Reset: `in_ready`=0 during reset cycle; after reset `result`=0, `flag`=0, `out_valid`=0, accumulator=0, state IDLE. Reset during MUL_BUSY discards the product.

## Timing
- ADD/SUB/ACC: accepted on edge E → `out_valid`=1 after E (latency 1). Back-to-back accept every cycle when `out_ready`=1 (throughput 1/cycle).
- MUL: edge E latches a, b, clears partial product, state→MUL_BUSY; edges E+1..E+WIDTH process bits; edge E+WIDTH loads `result`, sets `out_valid`, returns IDLE. Latency WIDTH+1; `in_ready`=0 for cycles after E through E+WIDTH.
- Simultaneous consume and accept in IDLE: old result leaves, new result appears after the same edge; no bubble.
- `out_ready` ignored when `out_valid`=0.

## Configuration
- `NIBBLE_ALU_SAT_EN` defined: ACC mode saturates — if acc + a + b ≥ 2^ACC_W, acc and `result` ← 2^ACC_W−1, `flag`=1; further ACC ops stay at max with `flag`=1 until `clear`.
- Undefined: ACC wraps modulo 2^ACC_W, `flag` = carry out of that operation only.

## Test plan
- Reset, then ADD a=9, b=8, out_ready=1 → next cycle `out_valid`=1, `result`=0x11, `flag`=1; prior: all outputs 0 after reset.
- SUB a=3, b=5 → `result`=0xFE, `flag`=1; SUB a=5, b=3 → `result`=0x02, `flag`=0.
- MUL a=15, b=13 → `in_ready`=0 for 4 cycles, `out_valid` 5 cycles after accept, `result`=0xC3, `flag`=0; reset asserted mid-MUL → `out_valid` stays 0, state IDLE.
- ACC 18× (a=15, b=15) from clear → wrap build: after 9th `result`=0x0E, `flag`=1; with `NIBBLE_ALU_SAT_EN`: `result`=0xFF, `flag`=1 from 9th onward; clear+ACC a=1,b=2 same cycle → `result`=0x03.
- Backpressure: ADD a=1,b=1 with out_ready=0 for 3 cycles → `result`=0x02 stable, `in_ready`=0; raise out_ready with new ADD a=2,b=2 valid → `result`=0x04 next cycle, no bubble.
